fifo_uart_tx: RTL and testbench

//   Read-side consumer of the 16x8 synchronous FIFO.
//   - Pops one byte at a time through the FIFO's rd_en/rd_data/empty interface.
//   - Serializes each byte onto a UART line, LSB first: 1 start bit, 8 data bits,

---
 rtl/fifo_uart_tx.sv | 123 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a synchronous FIFO: pops one byte per frame and sends it LSB first
// with a start bit, optional even parity and one or two stop bits.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;

            if (state == START || state == DATA || state == PARITY || state == STOP)
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;

            case (state)
                IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: state <= LOAD;
                LOAD: begin
                    shreg  <= fifo_rd_data;
                    parity <= ^fifo_rd_data;
                    tx     <= 1'b0;
                    state  <= START;
                end
                START: begin
                    if (baud_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                tx    <= parity;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
                STOP: begin
                    // Registered one cycle ahead so the pulse lands on the last stop-bit clock.
                    tx_done <= (bit_cnt == STOP_LAST) && (baud_cnt == BAUD_PRE);
                    if (baud_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx with an attached 16x8 FIFO model; a negedge monitor decodes tx frames
// and compares them against bytes queued at write time.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 11 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    // FIFO model: empty is registered from the previous count, so it lags by one cycle.
    logic       fifo_rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem [16];
    logic [3:0] wptr, rptr;
    int         fcount, fnext;

    always @(posedge clk) begin
        if (fifo_rst) begin
            wptr <= 4'd0; rptr <= 4'd0; fcount <= 0;
            fifo_empty <= 1'b1; fifo_rd_data <= 8'h00;
        end else begin
            fnext = fcount;
            if (wr_en && fcount < 16) begin
                mem[wptr] <= wr_data; wptr <= wptr + 4'd1; fnext = fnext + 1;
            end
            if (fifo_rd_en && fcount > 0) begin
                fifo_rd_data <= mem[rptr]; rptr <= rptr + 4'd1; fnext = fnext - 1;
            end
            fcount     <= fnext;
            fifo_empty <= (fcount == 0);
        end
    end

    int         checks = 0, errors = 0;
    logic [7:0] exp_q [$];
    int         gaps_q [$];
    int         pops = 0, dones = 0, stray_done = 0, stray_frames = 0;
    bit         in_frame = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic void compare_frame(input logic [FRAME-1:0] aw, input logic [FRAME-1:0] ad);
        logic [7:0]       b;
        logic [10:0]      bits;
        logic [FRAME-1:0] ew, ed;
        if (exp_q.size() == 0) begin
            stray_frames++;
            return;
        end
        b    = exp_q.pop_front();
        bits = {1'b1, ^b, b, 1'b0};
        for (int i = 0; i < FRAME; i++) ew[i] = bits[i / CPB];
        ed = '0;
        ed[FRAME-1] = 1'b1;
        check("frame_wave", 64'(aw), 64'(ew));
        check("frame_done", 64'(ad), 64'(ed));
    endfunction

    // Monitor: samples on negedge, well away from the active edge.
    int               idx = 0, gap = -1;
    logic [FRAME-1:0] aw, ad;
    logic             prev_empty = 1'b1;

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            pops++;
            check("pop_guard", {62'd0, prev_empty, tx_done}, 64'd0);
        end
        prev_empty = fifo_empty;
        if (tx_done) dones++;
        if (rst) begin
            if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
            in_frame = 1'b0;
            gap = -1;
        end else begin
            if (!in_frame) begin
                if (tx_done) stray_done++;
                if (tx == 1'b0) begin
                    in_frame = 1'b1;
                    idx = 0;
                    if (gap >= 0) gaps_q.push_back(gap);
                end else if (gap >= 0) begin
                    gap++;
                end
            end
            if (in_frame) begin
                aw[idx] = tx;
                ad[idx] = tx_done;
                idx++;
                if (idx == FRAME) begin
                    in_frame = 1'b0;
                    gap = 0;
                    compare_frame(aw, ad);
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        if (fcount < 16) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(fcount == 0 && !busy && !in_frame) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n >= budget), 64'd0);
    endtask

    int n, bad, p0, d0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then idle with an empty FIFO
        repeat (3) @(negedge clk);
        check("reset_state", {60'd0, tx, busy, fifo_rd_en, tx_done}, 64'b1000);
        rst = 1'b0; fifo_rst = 1'b0; tx_en = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(tx == 1'b1 && !busy && !fifo_rd_en)) bad++;
        end
        check("idle_empty_100", bad, 0);

        // 2: single byte, start latency and one done pulse
        p0 = pops; d0 = dones;
        write_byte(8'hA5);
        n = 0;
        while (fifo_empty && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (tx && n < 20) begin @(negedge clk); n++; end
        check("start_latency", n, 3);
        wait_idle("t2_idle", 200);
        check("t2_pops", pops - p0, 1);
        check("t2_dones", dones - d0, 1);

        // 3: back-to-back frames with three idle-high clocks between them
        gaps_q.delete();
        p0 = pops;
        write_byte(8'h00); write_byte(8'hFF); write_byte(8'h3C);
        wait_idle("t3_idle", 400);
        check("t3_pops", pops - p0, 3);
        check("t3_gaps", {32'(gaps_q.size()), 16'(gaps_q.size() > 1 ? gaps_q[1] : -1),
                          16'(gaps_q.size() > 2 ? gaps_q[2] : -1)}, {32'd3, 16'd3, 16'd3});
        check("t3_end", {62'd0, fifo_empty, busy}, 64'b10);

        // 4: tx_en dropped mid-frame holds the second byte until re-enabled
        p0 = pops; d0 = dones;
        write_byte(8'h5A); write_byte(8'hC3);
        n = 0;
        while (!busy && n < 20) begin @(negedge clk); n++; end
        tx_en = 1'b0;
        n = 0;
        while (dones - d0 < 1 && n < 100) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        check("t4_hold_pops", pops - p0, 1);
        check("t4_hold_dones", dones - d0, 1);
        check("t4_hold_busy", busy, 0);
        tx_en = 1'b1;
        wait_idle("t4_idle", 200);
        check("t4_pops", pops - p0, 2);

        // 5: reset during data bit 3 aborts the frame; the queued byte follows intact
        p0 = pops;
        write_byte(8'h96); write_byte(8'h4B);
        n = 0;
        while (tx && n < 20) begin @(negedge clk); n++; end
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", {62'd0, tx, busy}, 64'b10);
        repeat (3) @(negedge clk);
        d0 = dones;
        #2 rst = 1'b0;
        wait_idle("t5_idle", 200);
        check("t5_pops", pops - p0, 2);
        check("t5_dones", dones - d0, 1);

        // 6: fill the FIFO with random bytes, then drain in order
        tx_en = 1'b0;
        p0 = pops; d0 = dones;
        for (int i = 0; i < 16; i++) write_byte(8'($urandom));
        check("t6_full", fcount, 16);
        tx_en = 1'b1;
        wait_idle("t6_idle", 16 * 60);
        check("t6_pops", pops - p0, 16);
        check("t6_dones", dones - d0, 16);

        // random bytes at random spacing
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            write_byte(8'($urandom));
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        wait_idle("rand_idle", 800);
        check("rand_pops", pops - p0, 10);

        check("stray_events", {32'(stray_done), 32'(stray_frames)}, 64'd0);
        check("exp_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
